// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-add multiplier using the shared ALU in ADD mode; define MUL_SEQ_EARLY_EXIT_EN to stop RUN once the remaining multiplier bits are zero
`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif
module alu_mul_seq #(
  parameter int REG_WIDTH = `REG_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [REG_WIDTH-1:0] op_a,
  input  logic [REG_WIDTH-1:0] op_b,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [REG_WIDTH-1:0] resp_data,
  output logic [2:0]           alu_sel,
  output logic [REG_WIDTH-1:0] alu_a,
  output logic [REG_WIDTH-1:0] alu_b,
  input  logic [REG_WIDTH-1:0] alu_res,
  output logic                 busy
);
  localparam int CW = $clog2(REG_WIDTH);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [CW-1:0] LAST_CNT = CW'(REG_WIDTH - 1);
  logic [1:0]           state;
  logic [REG_WIDTH-1:0] acc;
  logic [REG_WIDTH-1:0] mcand;
  logic [REG_WIDTH-1:0] mplier;
  logic [CW-1:0]        cnt;
  logic                 last;
  // final RUN step: fixed count, or optionally when no multiplier bits remain
  always_comb begin
`ifdef MUL_SEQ_EARLY_EXIT_EN
    last = (cnt == LAST_CNT) || (mplier[REG_WIDTH-1:1] == '0);
`else
    last = cnt == LAST_CNT;
`endif
  end
  // sequencer state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          acc    <= '0;
          mcand  <= op_a;
          mplier <= op_b;
          cnt    <= '0;
          state  <= RUN;
        end
        RUN: begin
          if (mplier[0]) acc <= alu_res;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (last) state <= DONE;
        end
        DONE: if (resp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  // handshake and ALU operands; ALU inputs are zero outside RUN so the owner can mux them
  always_comb begin
    req_ready  = state == IDLE;
    resp_valid = state == DONE;
    busy       = state != IDLE;
    resp_data  = acc;
    alu_sel    = 3'b000;
    alu_a      = state == RUN ? acc : '0;
    alu_b      = state == RUN ? mcand : '0;
  end
endmodule
